// File: rtl/apx_cfg_int_add.sv
`default_nettype none
// ============================================================================
// Module   : apx_cfg_int_add
// Brief    : Two-stage valid/ready unsigned adder. The operator occupies the
//            top OP_BITWIDTH bits of the data path. A run-time configuration
//            register selects how many operand LSBs are zeroed, and whether a
//            carry-out saturates the result or lets it wrap.
// Revision : 1.0  initial release
// ============================================================================
module apx_cfg_int_add #(
    parameter int OP_BITWIDTH        = 16,
    parameter int DATA_PATH_BITWIDTH = 16,
    localparam int TW                = $clog2(OP_BITWIDTH + 1)
) (
    input  logic                          clk,
    input  logic                          rst,        // asynchronous, active-low
    input  logic                          in_valid,
    output logic                          in_ready,
    input  logic [DATA_PATH_BITWIDTH-1:0] a,
    input  logic [DATA_PATH_BITWIDTH-1:0] b,
    input  logic                          cfg_we,
    input  logic [TW-1:0]                 cfg_trunc,
    input  logic                          cfg_sat,
    output logic                          out_valid,
    input  logic                          out_ready,
    output logic [DATA_PATH_BITWIDTH-1:0] c,
    output logic                          c_ovf,
    output logic                          busy
);

    // Number of ignored data-path LSBs below the operator field.
    localparam int c_PAD = DATA_PATH_BITWIDTH - OP_BITWIDTH;

    // Bits at or above the truncation count survive; the rest are zeroed.
    function automatic logic [OP_BITWIDTH-1:0] f_keep_mask(input logic [TW-1:0] trunc);
        logic [OP_BITWIDTH-1:0] m;
        for (int i = 0; i < OP_BITWIDTH; i++) begin
            m[i] = (i >= int'(trunc));
        end
        return m;
    endfunction

    // Configuration register
    logic [TW-1:0]           r_cfg_trunc;
    logic                    r_cfg_sat;

    // Stage 1: masked operands plus the config snapshot of this transaction
    logic                    r_s1_valid;
    logic [OP_BITWIDTH-1:0]  r_s1_a;
    logic [OP_BITWIDTH-1:0]  r_s1_b;
    logic [TW-1:0]           r_s1_trunc;
    logic                    r_s1_sat;

    // Stage 2: final result presented on the output
    logic                          r_s2_valid;
    logic [DATA_PATH_BITWIDTH-1:0] r_c;
    logic                          r_c_ovf;

    logic [TW-1:0]                 w_trunc_clamped;
    logic [OP_BITWIDTH-1:0]        w_in_mask;
    logic [OP_BITWIDTH-1:0]        w_s1_mask;
    logic [OP_BITWIDTH-1:0]        w_op_a;
    logic [OP_BITWIDTH-1:0]        w_op_b;
    logic [OP_BITWIDTH:0]          w_sum;
    logic [OP_BITWIDTH-1:0]        w_res;
    logic [DATA_PATH_BITWIDTH-1:0] w_c_next;
    logic                          w_s2_adv;
    logic                          w_accept;

    // Operator field is the top of each data-path word.
    assign w_op_a = a[DATA_PATH_BITWIDTH-1 -: OP_BITWIDTH];
    assign w_op_b = b[DATA_PATH_BITWIDTH-1 -: OP_BITWIDTH];

    // Handshake: stage 2 frees when empty or drained; stage 1 frees when empty
    // or able to move into stage 2. in_ready never looks at in_valid.
    assign w_s2_adv = !r_s2_valid || out_ready;
    assign in_ready = !r_s1_valid || w_s2_adv;
    assign w_accept = in_valid && in_ready;

    // Truncation beyond the operator width means every bit is dropped.
    assign w_trunc_clamped = (cfg_trunc > TW'(OP_BITWIDTH)) ? TW'(OP_BITWIDTH) : cfg_trunc;

    // Masks: one for incoming operands, one for the saturation pattern.
    assign w_in_mask = f_keep_mask(r_cfg_trunc);
    assign w_s1_mask = f_keep_mask(r_s1_trunc);

    // Add at operator width plus carry; saturation replaces the result with
    // all-ones in the untruncated bits so truncated bits remain zero.
    assign w_sum    = {1'b0, r_s1_a} + {1'b0, r_s1_b};
    assign w_res    = (r_s1_sat && w_sum[OP_BITWIDTH]) ? w_s1_mask : w_sum[OP_BITWIDTH-1:0];
    assign w_c_next = DATA_PATH_BITWIDTH'(w_res) << c_PAD;

    // Configuration register load; a write affects only later accepts.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_cfg_trunc <= '0;
            r_cfg_sat   <= 1'b0;
        end else if (cfg_we) begin
            r_cfg_trunc <= w_trunc_clamped;
            r_cfg_sat   <= cfg_sat;
        end
    end

    // Stage 1: capture masked operands with the pre-edge config.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_s1_valid <= 1'b0;
            r_s1_a     <= '0;
            r_s1_b     <= '0;
            r_s1_trunc <= '0;
            r_s1_sat   <= 1'b0;
        end else if (w_accept) begin
            r_s1_valid <= 1'b1;
            r_s1_a     <= w_op_a & w_in_mask;
            r_s1_b     <= w_op_b & w_in_mask;
            r_s1_trunc <= r_cfg_trunc;
            r_s1_sat   <= r_cfg_sat;
        end else if (w_s2_adv) begin
            r_s1_valid <= 1'b0;
        end
    end

    // Stage 2: register result and carry; hold while stalled downstream.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_s2_valid <= 1'b0;
            r_c        <= '0;
            r_c_ovf    <= 1'b0;
        end else if (w_s2_adv) begin
            r_s2_valid <= r_s1_valid;
            if (r_s1_valid) begin
                r_c     <= w_c_next;
                r_c_ovf <= w_sum[OP_BITWIDTH];
            end
        end
    end

    assign out_valid = r_s2_valid;
    assign c         = r_c;
    assign c_ovf     = r_c_ovf;
    assign busy      = r_s1_valid || r_s2_valid;

endmodule
`default_nettype wire
